// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks destination registers of instructions in flight between ID and WB
// and raises a combinational stall request when an ID source register is
// still pending. A saturating counter records stall cycles.
//
// Optional feature macro: FORWARDING_EN
//   undefined : every tracked stage can cause a stall (no bypass network).
//   defined   : an EXE/MEM forwarding unit exists, so only a load sitting in
//               stage 0 (EXE) can stall the consumer (load-use, one bubble).
//
// Handshake/flow: there is no valid/ready pair here. The ID stage presents
// an instruction every cycle; hazard=1 means "do not advance ID", and the
// scoreboard inserts a bubble into stage 0 on that edge. freeze holds every
// register; flush squashes the ID instruction and takes priority over hazard.
module hazard_scoreboard #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     id_wb_en,
  input  logic                     id_mem_read,
  input  logic [REG_ADDR_W-1:0]    id_dest,
  input  logic [REG_ADDR_W-1:0]    src1,
  input  logic [REG_ADDR_W-1:0]    src2,
  input  logic                     two_src,
  input  logic                     ignore_hazard,
  output logic                     hazard,
  output logic [2**REG_ADDR_W-1:0] busy_mask,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int NREGS = 2**REG_ADDR_W;

  // Stage k: k=0 is EXE, k=1 is MEM, ... The tag leaving DEPTH-1 is in WB,
  // where the register file writes on the falling edge, so it is dropped.
  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 load_q,  load_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q,  dest_d;
  logic [CNT_W-1:0]                 cnt_q,   cnt_d;

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] stage_hit;
  logic             issue_ok;
  logic             count_stall;

  // Load flags are only consulted by the forwarding variant; keep them
  // referenced so both builds stay tidy.
  logic load_flags_unused;
  assign load_flags_unused = ^load_q;

  // Which stages are allowed to raise a stall.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < DEPTH; k++) begin
`ifdef FORWARDING_EN
      // Bypass covers everything except a load still in EXE.
      eligible[k] = (k == 0) && load_q[k];
`else
      eligible[k] = 1'b1;
`endif
    end
  end

  // Source-register comparison against every tracked tag (zero latency).
  always_comb begin
    stage_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_hit[k] = eligible[k] && valid_q[k] &&
                     ((dest_q[k] == src1) || (two_src && (dest_q[k] == src2)));
    end
    hazard = !ignore_hazard && (|stage_hit);
  end

  // Issue and stall-count qualification; flush wins over hazard for both.
  always_comb begin
    issue_ok    = id_wb_en && !hazard && !flush;
    count_stall = hazard && !flush;
  end

  // Next-state for the tag shift pipeline and the saturating counter.
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      // A stall or flush turns stage 0 into a bubble (valid=0); older tags
      // keep draining, so any stall clears within DEPTH edges.
      valid_d[0] = issue_ok;
      load_d[0]  = id_mem_read && issue_ok;
      dest_d[0]  = id_dest;
      if (count_stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending-register mask decoded from registered tags only.
  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k]) begin
        busy_mask[dest_q[k]] = 1'b1;
      end
    end
  end

  assign stall_count = cnt_q;

  // NREGS documents the mask width for readers; tie it into a check-free use.
  logic [31:0] nregs_unused;
  assign nregs_unused = 32'(NREGS);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard (DEPTH=2, REG_ADDR_W=4, CNT_W=4 so that
// counter saturation is reachable in a short run).
module tb_hazard_scoreboard;

  localparam int DEPTH = 2;
  localparam int RW    = 4;
  localparam int CW    = 4;
  localparam int NR    = 16;

  logic          clk;
  logic          rst;
  logic          freeze;
  logic          flush;
  logic          id_wb_en;
  logic          id_mem_read;
  logic [RW-1:0] id_dest;
  logic [RW-1:0] src1;
  logic [RW-1:0] src2;
  logic          two_src;
  logic          ignore_hazard;
  logic          hazard;
  logic [NR-1:0] busy_mask;
  logic [CW-1:0] stall_count;

  hazard_scoreboard #(
    .DEPTH(DEPTH),
    .REG_ADDR_W(RW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .flush(flush),
    .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read),
    .id_dest(id_dest),
    .src1(src1),
    .src2(src2),
    .two_src(two_src),
    .ignore_hazard(ignore_hazard),
    .hazard(hazard),
    .busy_mask(busy_mask),
    .stall_count(stall_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          frz;
    logic          fl;
    logic          wb;
    logic          mr;
    logic [RW-1:0] dest;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;
    logic          ts;
    logic          ig;
    logic          eh;
    logic [NR-1:0] eb;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t vecs[$];

  // expected {hazard, busy_mask, stall_count}
  logic [NR+CW:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic add(input logic r, input logic frz, input logic fl,
                     input logic wb, input logic mr, input logic [RW-1:0] dest,
                     input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                     input logic ts, input logic ig, input logic eh,
                     input logic [NR-1:0] eb, input logic [CW-1:0] ec);
    vec_t v;
    v.rst = r;  v.frz = frz; v.fl = fl; v.wb = wb; v.mr = mr;
    v.dest = dest; v.s1 = s1; v.s2 = s2; v.ts = ts; v.ig = ig;
    v.eh = eh; v.eb = eb; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [NR-1:0] eb, input logic [CW-1:0] ec);
    add(0, 0, 0, 0, 0, 4'd0, 4'd15, 4'd15, 0, 0, 1'b0, eb, ec);
  endtask

  // ---------------- driver ----------------
  task automatic drive_row(input vec_t v);
    @(posedge clk);
    #1;
    rst           = v.rst;
    freeze        = v.frz;
    flush         = v.fl;
    id_wb_en      = v.wb;
    id_mem_read   = v.mr;
    id_dest       = v.dest;
    src1          = v.s1;
    src2          = v.s2;
    two_src       = v.ts;
    ignore_hazard = v.ig;
    exp_q.push_back({v.eh, v.eb, v.ec});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_row(input int row);
    logic [NR+CW:0] e;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL row%0d queue: actual=empty required=entry", row);
    end else begin
      e = exp_q.pop_front();
      if (hazard !== e[NR+CW]) begin
        errors++;
        $display("FAIL row%0d hazard: actual=%b required=%b", row, hazard, e[NR+CW]);
      end
      checks++;
      if (busy_mask !== e[NR+CW-1:CW]) begin
        errors++;
        $display("FAIL row%0d busy_mask: actual=%h required=%h", row, busy_mask, e[NR+CW-1:CW]);
      end
      checks++;
      if (stall_count !== e[CW-1:0]) begin
        errors++;
        $display("FAIL row%0d stall_count: actual=%0d required=%0d", row, stall_count, e[CW-1:0]);
      end
    end
  endtask

  function automatic logic [CW-1:0] sat(input int n);
    return (n > 15) ? 4'd15 : CW'(n);
  endfunction

  // ---------------- test ----------------
  initial begin
    int n;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; id_wb_en = 1'b0;
    id_mem_read = 1'b0; id_dest = '0; src1 = 4'd15; src2 = 4'd15;
    two_src = 1'b0; ignore_hazard = 1'b0;

`ifndef FORWARDING_EN
    // reset with a would-be issue, then first issue of R3
    add(1, 0, 0, 1, 0, 4'd3, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 0);
    add(1, 0, 0, 1, 0, 4'd3, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 1, 0, 4'd3, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 0);
    idle(16'h0008, 0);
    idle(16'h0008, 0);
    idle(16'h0000, 0);
    // RAW: ADD R1 then SUB src1=R1 -> two stall cycles
    add(0, 0, 0, 1, 0, 4'd1, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 1, 0, 4'd2, 4'd1,  4'd15, 0, 0, 1, 16'h0002, 0);
    add(0, 0, 0, 1, 0, 4'd2, 4'd1,  4'd15, 0, 0, 1, 16'h0002, 1);
    add(0, 0, 0, 1, 0, 4'd2, 4'd1,  4'd15, 0, 0, 0, 16'h0000, 2);
    idle(16'h0004, 2);
    idle(16'h0004, 2);
    // two_src / ignore_hazard gating on R5
    add(0, 0, 0, 1, 0, 4'd5, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 2);
    add(0, 0, 0, 1, 0, 4'd5, 4'd15, 4'd5,  0, 0, 0, 16'h0020, 2);
    add(0, 0, 0, 1, 0, 4'd5, 4'd15, 4'd5,  1, 1, 0, 16'h0020, 2);
    add(0, 0, 0, 0, 0, 4'd0, 4'd15, 4'd5,  1, 0, 1, 16'h0020, 2);
    idle(16'h0020, 3);
    idle(16'h0000, 3);
    // freeze for 4 cycles while stalled on R2
    add(0, 0, 0, 1, 0, 4'd2, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 3);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 1, 0, 4'd6, 4'd2, 4'd15, 0, 0, 1, 16'h0004, 3);
    add(0, 0, 0, 1, 0, 4'd6, 4'd2, 4'd15, 0, 0, 1, 16'h0004, 3);
    add(0, 0, 0, 1, 0, 4'd6, 4'd2, 4'd15, 0, 0, 1, 16'h0004, 4);
    add(0, 0, 0, 1, 0, 4'd6, 4'd2, 4'd15, 0, 0, 0, 16'h0000, 5);
    idle(16'h0040, 5);
    idle(16'h0040, 5);
    // flush squashes R7; flushed hazard cycle is not counted
    add(0, 0, 1, 1, 0, 4'd7, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 5);
    add(0, 0, 0, 1, 0, 4'd8, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 5);
    add(0, 0, 1, 1, 0, 4'd7, 4'd8,  4'd15, 0, 0, 1, 16'h0100, 5);
    idle(16'h0100, 5);
    idle(16'h0000, 5);
    // reset in the middle of a stall
    add(0, 0, 0, 1, 0, 4'd9, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 5);
    add(0, 0, 0, 0, 0, 4'd0, 4'd9,  4'd15, 0, 0, 1, 16'h0200, 5);
    add(1, 0, 0, 0, 0, 4'd0, 4'd9,  4'd15, 0, 0, 0, 16'h0000, 0);
    idle(16'h0000, 0);
    // saturation: rounds of one issue + two stalls, 20 stall cycles total
    n = 0;
    for (int r = 0; r < 10; r++) begin
      add(0, 0, 0, 1, 0, 4'd1, 4'd15, 4'd15, 0, 0, 0, 16'h0000, sat(n));
      add(0, 0, 0, 0, 0, 4'd0, 4'd1,  4'd15, 0, 0, 1, 16'h0002, sat(n));
      add(0, 0, 0, 0, 0, 4'd0, 4'd1,  4'd15, 0, 0, 1, 16'h0002, sat(n + 1));
      n += 2;
    end
    idle(16'h0000, 4'd15);
`else
    add(1, 0, 0, 0, 0, 4'd0, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 0);
    idle(16'h0000, 0);
    // LDR R4 then dependent ADD -> exactly one bubble
    add(0, 0, 0, 1, 1, 4'd4, 4'd15, 4'd15, 0, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 1, 0, 4'd5, 4'd4,  4'd15, 0, 0, 1, 16'h0010, 0);
    add(0, 0, 0, 1, 0, 4'd5, 4'd4,  4'd15, 0, 0, 0, 16'h0010, 1);
    // MOV R4 (non-load) then dependent instruction -> no stall
    add(0, 0, 0, 1, 0, 4'd4, 4'd15, 4'd15, 0, 0, 0, 16'h0020, 1);
    add(0, 0, 0, 0, 0, 4'd0, 4'd4,  4'd15, 0, 0, 0, 16'h0030, 1);
    idle(16'h0010, 1);
    idle(16'h0000, 1);
    // saturation: rounds of LDR + one stall
    n = 1;
    for (int r = 0; r < 19; r++) begin
      add(0, 0, 0, 1, 1, 4'd1, 4'd15, 4'd15, 0, 0, 0,
          (r == 0) ? 16'h0000 : 16'h0002, sat(n));
      add(0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd15, 0, 0, 1, 16'h0002, sat(n));
      n += 1;
    end
    idle(16'h0002, 4'd15);
    idle(16'h0000, 4'd15);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive_row(vecs[i]);
      check_row(i);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d left required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks destination registers of instructions in flight between ID and WB in the 5-stage ARM pipeline.
- Drives the `hazard` stall input of the ID stage, which forces a bubble and holds IF/ID.
- Compares ID source registers against a shift pipeline of in-flight destination tags, with a saturating stall counter for performance monitoring.
- Sits beside the ID stage; fed by ID decode outputs, the EXE-stage branch flush and the global memory freeze.

Parameters:
- DEPTH, 2, number of tracked stages after ID (stage 0 = EXE, stage 1 = MEM); legal 1..4.
- REG_ADDR_W, 4, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- freeze  input  1  global pipeline freeze (memory wait); holds all state.
- flush  input  1  branch taken in EXE; instruction in ID is squashed.
- id_wb_en  input  1  ID instruction writes a register (post-condition-check control).
- id_mem_read  input  1  ID instruction is a load.
- id_dest  input  REG_ADDR_W  ID destination register.
- src1  input  REG_ADDR_W  ID first source (Rn).
- src2  input  REG_ADDR_W  ID second source (Rm or Rd for stores).
- two_src  input  1  src2 is actually read.
- ignore_hazard  input  1  ID instruction needs no operands (e.g. branch); suppress hazard.
- hazard  output  1  stall request to ID stage / IF freeze.
- busy_mask  output  2**REG_ADDR_W  bit r set when register r is pending in any valid stage.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- State: per stage k, {valid_k, dest_k, load_k}. Reset (async, rst=1): all valid_k=0, dest_k=0, load_k=0, stall_count=0. Hence hazard=0 and busy_mask=0 during and after reset.
- match(s,k) = valid_k && dest_k==s.
- hazard (combinational, zero latency) = !ignore_hazard && OR over eligible k of (match(src1,k) || (two_src && match(src2,k))).
- Eligible stages without the optional feature: all k in 0..DEPTH-1.
- busy_mask is decoded purely from registered state.
- Issue: issue_ok = id_wb_en && !hazard && !flush.
- Clock edge with freeze=0:
  - stage0 <= {issue_ok, id_dest, id_mem_read && issue_ok}.
  - stage k <= stage k-1 for k>=1.
  - The tag leaving stage DEPTH-1 is dropped; the instruction is then in WB and the register file writes on the negative edge.
- Clock edge with freeze=1: all stages and stall_count hold; hazard is still re-evaluated combinationally.
- Stall with no flush: a bubble (valid=0) enters stage 0, and older tags keep advancing. A stall therefore resolves after at most DEPTH cycles.
- flush=1: stage0 receives a bubble regardless of hazard. flush has priority over hazard for issue and for counting.
- stall_count: increments by 1 on each edge with hazard && !freeze && !flush. It saturates at all ones and never wraps.
- Register 15 is not special-cased.
- Reset mid-stall: hazard drops immediately (async) and all tags are cleared.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: EXE/MEM forwarding unit present. Only stage 0 entries with load_k=1 are eligible for hazard (load-use stall, exactly 1 bubble). busy_mask still reports all valid stages.
- Undefined: all DEPTH stages eligible; behaviour as above.

Test Plan:
- Reset: rst=1 for 2 cycles with id_wb_en=1 → hazard=0, busy_mask=0, stall_count=0; after release, the first issue of id_dest=3 gives busy_mask=0x0008 next cycle.
- RAW without forwarding, DEPTH=2:
  - Issue ADD R1 (id_wb_en=1, id_dest=1).
  - Next ID SUB with src1=1 → hazard=1 for exactly 2 cycles, then 0.
  - stall_count=2, and a bubble is observed in stage0 on both edges.
- two_src gating:
  - stage0 holds dest=5; ID src2=5, two_src=0 → hazard=0.
  - Same with two_src=1 → hazard=1.
  - With ignore_hazard=1 → hazard=0.
- Freeze: hazard=1 pending on R2, freeze=1 for 4 cycles → hazard stays 1, stall_count unchanged, busy_mask unchanged; the stall resolves 2 cycles after freeze drops.
- Flush: ID instruction id_wb_en=1, id_dest=7 with flush=1 → bit 7 of busy_mask never set; hazard=1 in the same cycle does not increment stall_count.
- FORWARDING_EN defined:
  - LDR R4 issued, then ADD src1=4 → hazard=1 for exactly 1 cycle, stall_count=1.
  - Non-load MOV R4 followed by a dependent instruction → hazard=0.
  - Saturation: force 2**CNT_W+3 stall cycles (CNT_W=4 build) → stall_count=15.
